dmem_access_ctrl: RTL

MEM-stage data-memory access controller on the consumer side of the EX/MEM pipeline register. It takes the registered memory-control bits, the effective address and the store data. It then runs a request/acknowledge transaction to a variable-latency data memory and drives the pipeline stall that holds EX/MEM and the upstream stages until the access completes. Load data goes to the MEM/WB register.

---
 rtl/mips_mem_pkg.sv | 21 ++
 rtl/dmem_access_ctrl_latch.sv | 26 ++
 rtl/dmem_access_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared MEM-stage definitions: FSM encodings, MEM_ctrl bit positions and datapath widths.
package mips_mem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  localparam int unsigned MEMREAD_BIT  = 1;
  localparam int unsigned MEMWRITE_BIT = 0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [ADDR_W-1:0] WORD_MASK = 32'hFFFF_FFFC;

  // Data memory is word-addressed; the byte offset is dropped.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & WORD_MASK;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_latch.sv
// Enable-gated capture register with asynchronous active-low clear.
module dmem_access_ctrl_latch
  import mips_mem_pkg::*;
#(
  parameter int unsigned Width = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] q_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else if (we_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory req/ack controller with pipeline stall and stall counter.
// Optional misaligned-access trap enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_access_ctrl
  import mips_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  MEM_ctrl_i,
  input  logic [31:0] ALU_output_i,
  input  logic [31:0] ALU_data_2_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] stall_cnt_o
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic        misalign_o
`endif
);

  localparam int unsigned ReqW = DATA_W + ADDR_W + 1;

  logic [1:0]        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;
  logic              access, misalign, accept, in_busy, ack_hit, rd_cap;
  logic [ReqW-1:0]   req_d, req_q;

  assign access = MEM_ctrl_i[MEMREAD_BIT] | MEM_ctrl_i[MEMWRITE_BIT];

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign   = access & (ALU_output_i[1:0] != 2'b00);
  assign misalign_o = misalign;
`else
  assign misalign = 1'b0;
`endif

  assign in_busy = (state_q == BUSY);
  assign accept  = (state_q == IDLE) & access & ~misalign;
  assign ack_hit = in_busy & mem_ack_i;
  assign rd_cap  = ack_hit & ~mem_we_o;
  assign stall_o = accept | in_busy;

  // MEM_ctrl 2'b11 decodes as a write since the write bit alone selects we.
  assign req_d = {MEM_ctrl_i[MEMWRITE_BIT], word_align(ALU_output_i), ALU_data_2_i};

  dmem_access_ctrl_latch #(
    .Width(ReqW)
  ) u_req_latch (
    .clk  (clk),
    .rst  (rst),
    .we_i (accept),
    .d_i  (req_d),
    .q_o  (req_q)
  );

  assign mem_we_o    = req_q[ReqW-1];
  assign mem_addr_o  = req_q[DATA_W +: ADDR_W];
  assign mem_wdata_o = req_q[DATA_W-1:0];

  dmem_access_ctrl_latch #(
    .Width(DATA_W)
  ) u_rdata_latch (
    .clk  (clk),
    .rst  (rst),
    .we_i (rd_cap),
    .d_i  (mem_rdata_i),
    .q_o  (rdata_o)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (mem_ack_i) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_req_d = (state_d == BUSY);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule
